// File: rtl/dekatron_step_scheduler_if.sv
// Command and pulse-drive bundle between the DPC control FSM (master) and the
// dekatron step scheduler (slave).
//   Req/Mode/Arg : command request, opcode and argument (master -> slave)
//   Ready        : scheduler idle, command accepted on Req & Ready
//   Busy/Done/Err: command progress, completion pulse and reject flag
//   PulseEn/Dec  : drive for the pulse sender's En and Dec inputs
//   Position     : current cathode of the dekatron
interface dekatron_step_scheduler_if #(
  parameter int unsigned ARG_W = 4
);

  logic             Req;
  logic [1:0]       Mode;
  logic [ARG_W-1:0] Arg;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic             PulseEn;
  logic             PulseDec;
  logic [ARG_W-1:0] Position;

  modport master (
    output Req, Mode, Arg,
    input  Ready, Busy, Done, Err, PulseEn, PulseDec, Position
  );

  modport slave (
    input  Req, Mode, Arg,
    output Ready, Busy, Done, Err, PulseEn, PulseDec, Position
  );

endinterface

// File: rtl/dekatron_step_scheduler.sv
// Sequencer for one dekatron pulse sender. Accepts increment / decrement /
// goto commands, drives the sender's En and Dec for whole pulse frames only,
// and tracks the cathode position.
//   hsClk : clock shared with the pulse sender
//   Rst   : synchronous active-high reset (asserted together with the sender's)
//   bus   : command handshake, pulse drive and position (slave side)
module dekatron_step_scheduler #(
  parameter int unsigned HSCLK_DIV = 10,
  parameter int unsigned DEK_COUNT = 10,
  parameter int unsigned ARG_W     = 4
) (
  input logic                     hsClk,
  input logic                     Rst,
  dekatron_step_scheduler_if.slave bus
);

  localparam int unsigned PH_W = (HSCLK_DIV > 1) ? $clog2(HSCLK_DIV) : 1;
  localparam int unsigned AW1  = ARG_W + 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HSCLK_DIV - 1);
  localparam logic [ARG_W-1:0] POS_LAST = ARG_W'(DEK_COUNT - 1);
  localparam logic [AW1-1:0]   DEK_W    = AW1'(DEK_COUNT);
  localparam logic [AW1-1:0]   HALF_W   = AW1'(DEK_COUNT / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_PULSE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [ARG_W-1:0] pos_q, pos_d;
  logic [ARG_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             dec_q, dec_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             phase_last_c;
  logic             cmd_dir_c;
  logic [ARG_W-1:0] cmd_cnt_c;
  logic             cmd_err_c;
  logic [AW1-1:0]   arg_w_c;
  logic [AW1-1:0]   pos_w_c;
  logic [AW1-1:0]   diff_c;
  logic [ARG_W-1:0] pos_step_c;

  assign phase_last_c = (phase_q == PH_LAST);

  // Command decode: direction, frame count and reject flag for the Req on the bus.
  always_comb begin
    cmd_dir_c = 1'b0;
    cmd_cnt_c = '0;
    cmd_err_c = 1'b0;
    arg_w_c   = {1'b0, bus.Arg};
    pos_w_c   = {1'b0, pos_q};
    diff_c    = '0;
    case (bus.Mode)
      2'b00: begin
        cmd_cnt_c = bus.Arg;
      end
      2'b01: begin
        cmd_dir_c = 1'b1;
        cmd_cnt_c = bus.Arg;
      end
      2'b10: begin
        if (arg_w_c >= DEK_W) begin
          cmd_err_c = 1'b1;
        end else begin
          // (Arg - Position) mod DEK_COUNT, both operands already in range
          if (arg_w_c >= pos_w_c) diff_c = arg_w_c - pos_w_c;
          else                    diff_c = arg_w_c + DEK_W - pos_w_c;
          // shortest way round; exact half-turn goes forward
          if (diff_c <= HALF_W) begin
            cmd_dir_c = 1'b0;
            cmd_cnt_c = diff_c[ARG_W-1:0];
          end else begin
            cmd_dir_c = 1'b1;
            cmd_cnt_c = ARG_W'(DEK_W - diff_c);
          end
        end
      end
      default: begin
        cmd_err_c = 1'b1;
      end
    endcase
  end

  // Position one cathode further in the latched direction, wrapping both ways.
  always_comb begin
    pos_step_c = pos_q;
    if (!dir_q) pos_step_c = (pos_q == POS_LAST) ? '0 : pos_q + ARG_W'(1);
    else        pos_step_c = (pos_q == '0) ? POS_LAST : pos_q - ARG_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_last_c ? '0 : phase_q + PH_W'(1);
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    en_d    = en_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          dir_d = cmd_dir_c;
          cnt_d = cmd_cnt_c;
          if (cmd_err_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cmd_cnt_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (phase_last_c) begin
            // already at a frame boundary: first frame starts next cycle
            state_d = S_PULSE;
            en_d    = 1'b1;
            dec_d   = cmd_dir_c;
          end else begin
            state_d = S_ALIGN;
            dec_d   = cmd_dir_c;
          end
        end
      end
      S_ALIGN: begin
        if (phase_last_c) begin
          state_d = S_PULSE;
          en_d    = 1'b1;
        end
      end
      S_PULSE: begin
        if (phase_last_c) begin
          pos_d = pos_step_c;
          if (cnt_q == ARG_W'(1)) begin
            state_d = S_DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - ARG_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dec_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        dec_d   = 1'b0;
      end
    endcase

    busy_d  = (state_d == S_ALIGN) || (state_d == S_PULSE);
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge hsClk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
  assign bus.PulseEn  = en_q;
  assign bus.PulseDec = dec_q;
  assign bus.Position = pos_q;

endmodule

// File: tb/tb_dekatron_step_scheduler.sv
// Directed bench for dekatron_step_scheduler (HSCLK_DIV=10, DEK_COUNT=10, ARG_W=4).
module tb_dekatron_step_scheduler;

  logic hsClk = 1'b0;
  logic Rst   = 1'b1;

  dekatron_step_scheduler_if #(.ARG_W(4)) bus ();

  dekatron_step_scheduler #(
    .HSCLK_DIV(10),
    .DEK_COUNT(10),
    .ARG_W    (4)
  ) dut (
    .hsClk(hsClk),
    .Rst  (Rst),
    .bus  (bus)
  );

  always #5 hsClk = ~hsClk;

  // Reference frame phase: 0 after reset, wraps 9 -> 0.
  int ph = 0;
  always @(posedge hsClk) begin
    if (Rst) ph <= 0;
    else     ph <= (ph == 9) ? 0 : ph + 1;
  end

  int vec  = 0;
  int errs = 0;

  task automatic tick();
    @(posedge hsClk);
    #1;
  endtask

  function automatic logic [3:0] step(input logic [3:0] p, input logic d);
    if (!d) return (p == 4'd9) ? 4'd0 : p + 4'd1;
    else    return (p == 4'd0) ? 4'd9 : p - 4'd1;
  endfunction

  // Issue one command and record what the scheduler did until Done.
  task automatic issue(input logic [1:0] mode, input logic [3:0] arg, input logic exp_dir,
                       output int ph_acc, output int lat, output int en_cyc, output int rises,
                       output bit dec_ok, output int steps, output bit pos_ok,
                       output int done_at, output logic err, output logic [3:0] fpos,
                       output logic busy_at_done, output logic ready_after);
    logic [3:0] prev_pos;
    logic       prev_en;
    ph_acc = ph; lat = -1; en_cyc = 0; rises = 0; dec_ok = 1'b1; steps = 0; pos_ok = 1'b1;
    done_at = -1; err = 1'bx; fpos = 4'hx; busy_at_done = 1'bx; ready_after = 1'bx;
    prev_pos = bus.Position;
    prev_en  = 1'b0;
    bus.Req = 1'b1; bus.Mode = mode; bus.Arg = arg;
    tick();
    bus.Req = 1'b0; bus.Mode = 2'b11; bus.Arg = 4'hF;
    for (int n = 1; n <= 600; n++) begin
      if (bus.PulseEn === 1'b1) begin
        en_cyc++;
        if (lat < 0) lat = n;
        if (!prev_en) rises++;
        if (bus.PulseDec !== exp_dir) dec_ok = 1'b0;
      end
      prev_en = (bus.PulseEn === 1'b1);
      if (bus.Position !== prev_pos) begin
        steps++;
        if (bus.Position !== step(prev_pos, exp_dir) || ph != 0) pos_ok = 1'b0;
        prev_pos = bus.Position;
      end
      if (bus.Done === 1'b1) begin
        done_at = n;
        err = bus.Err;
        fpos = bus.Position;
        busy_at_done = bus.Busy;
        if (en_cyc > 0 && bus.PulseDec !== exp_dir) dec_ok = 1'b0;
        tick();
        ready_after = bus.Ready;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 12 && ph != p; i++) tick();
  endtask

  task automatic test_reset();
    bus.Req = 1'b0; bus.Mode = 2'b00; bus.Arg = 4'd0;
    Rst = 1'b1;
    tick(); tick();
    vec++; if (bus.Ready !== 1'b1)     begin errs++; $display("FAIL reset_ready got %b want 1", bus.Ready); end
    vec++; if (bus.Busy !== 1'b0)      begin errs++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    vec++; if (bus.Done !== 1'b0)      begin errs++; $display("FAIL reset_done got %b want 0", bus.Done); end
    vec++; if (bus.Err !== 1'b0)       begin errs++; $display("FAIL reset_err got %b want 0", bus.Err); end
    vec++; if (bus.PulseEn !== 1'b0)   begin errs++; $display("FAIL reset_en got %b want 0", bus.PulseEn); end
    vec++; if (bus.PulseDec !== 1'b0)  begin errs++; $display("FAIL reset_dec got %b want 0", bus.PulseDec); end
    vec++; if (bus.Position !== 4'd0)  begin errs++; $display("FAIL reset_pos got %0d want 0", bus.Position); end
    vec++; if (dut.phase_q !== 4'd0)   begin errs++; $display("FAIL reset_phase got %0d want 0", dut.phase_q); end
    Rst = 1'b0;
  endtask

  task automatic test_inc();
    int pa, lat, enc, ris, steps, done_at; bit dok, pok; logic err, busy, rdy; logic [3:0] fp;
    do_reset();
    wait_phase(4);
    issue(2'b00, 4'd3, 1'b0, pa, lat, enc, ris, dok, steps, pok, done_at, err, fp, busy, rdy);
    vec++; if (pa != 4)       begin errs++; $display("FAIL inc_accept_phase got %0d want 4", pa); end
    vec++; if (lat != 6)      begin errs++; $display("FAIL inc_latency got %0d want 6", lat); end
    vec++; if (enc != 30 || ris != 1) begin errs++; $display("FAIL inc_en_cycles got %0d/%0d want 30/1", enc, ris); end
    vec++; if (!dok)          begin errs++; $display("FAIL inc_dec got bad want 0"); end
    vec++; if (steps != 3 || !pok) begin errs++; $display("FAIL inc_pos_steps got %0d ok=%0b want 3 ok=1", steps, pok); end
    vec++; if (done_at != 36) begin errs++; $display("FAIL inc_done_at got %0d want 36", done_at); end
    vec++; if (err !== 1'b0 || fp !== 4'd3) begin errs++; $display("FAIL inc_result got err=%b pos=%0d want err=0 pos=3", err, fp); end
    vec++; if (busy !== 1'b0 || rdy !== 1'b1) begin errs++; $display("FAIL inc_handshake got busy=%b ready=%b want 0/1", busy, rdy); end
  endtask

  task automatic test_dec();
    int pa, lat, enc, ris, steps, done_at; bit dok, pok; logic err, busy, rdy; logic [3:0] fp;
    do_reset();
    issue(2'b00, 4'd2, 1'b0, pa, lat, enc, ris, dok, steps, pok, done_at, err, fp, busy, rdy);
    vec++; if (fp !== 4'd2) begin errs++; $display("FAIL dec_setup_pos got %0d want 2", fp); end
    wait_phase(7);
    issue(2'b01, 4'd4, 1'b1, pa, lat, enc, ris, dok, steps, pok, done_at, err, fp, busy, rdy);
    vec++; if (lat != 10 - pa) begin errs++; $display("FAIL dec_latency got %0d want %0d", lat, 10 - pa); end
    vec++; if (enc != 40 || ris != 1) begin errs++; $display("FAIL dec_en_cycles got %0d/%0d want 40/1", enc, ris); end
    vec++; if (!dok)           begin errs++; $display("FAIL dec_dir got bad want 1"); end
    vec++; if (steps != 4 || !pok) begin errs++; $display("FAIL dec_pos_steps got %0d ok=%0b want 4 ok=1", steps, pok); end
    vec++; if (err !== 1'b0 || fp !== 4'd8 || done_at != lat + 40)
      begin errs++; $display("FAIL dec_result got err=%b pos=%0d at=%0d want err=0 pos=8 at=%0d", err, fp, done_at, lat + 40); end
  endtask

  // Starting at Position 8 (left by test_dec).
  task automatic test_goto();
    logic [3:0] t_arg [8] = '{4'd1, 4'd8, 4'd3, 4'd1, 4'd4, 4'd1, 4'd9, 4'd9};
    logic       t_dir [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int         t_cnt [8] = '{3,    3,    5,    2,    3,    3,    2,    0};
    int         t_ph  [8] = '{9,    0,    5,    2,    8,    1,    3,    6};
    int pa, lat, enc, ris, steps, done_at; bit dok, pok; logic err, busy, rdy; logic [3:0] fp;
    for (int i = 0; i < 8; i++) begin
      wait_phase(t_ph[i]);
      issue(2'b10, t_arg[i], t_dir[i], pa, lat, enc, ris, dok, steps, pok, done_at, err, fp, busy, rdy);
      vec++;
      if (enc != t_cnt[i] * 10 || steps != t_cnt[i] || !pok || !dok) begin
        errs++; $display("FAIL goto%0d_frames got en=%0d steps=%0d pok=%0b dok=%0b want en=%0d steps=%0d dir=%0b",
                         i, enc, steps, pok, dok, t_cnt[i] * 10, t_cnt[i], t_dir[i]);
      end
      vec++;
      if (fp !== t_arg[i] || err !== 1'b0) begin
        errs++; $display("FAIL goto%0d_result got pos=%0d err=%b want pos=%0d err=0", i, fp, err, t_arg[i]);
      end
      vec++;
      if (t_cnt[i] == 0 ? (done_at != 1) : (lat != 10 - pa || done_at != lat + t_cnt[i] * 10)) begin
        errs++; $display("FAIL goto%0d_timing got lat=%0d done=%0d want lat=%0d done=%0d",
                         i, lat, done_at, 10 - pa, (t_cnt[i] == 0) ? 1 : 10 - pa + t_cnt[i] * 10);
      end
    end
  endtask

  // Position is 9 here.
  task automatic test_reject();
    logic [1:0] m [2] = '{2'b10, 2'b11};
    logic [3:0] a [2] = '{4'd12, 4'd2};
    int pa, lat, enc, ris, steps, done_at; bit dok, pok; logic err, busy, rdy; logic [3:0] fp;
    for (int i = 0; i < 2; i++) begin
      issue(m[i], a[i], 1'b0, pa, lat, enc, ris, dok, steps, pok, done_at, err, fp, busy, rdy);
      vec++; if (enc != 0 || steps != 0) begin errs++; $display("FAIL reject%0d_pulses got en=%0d steps=%0d want 0/0", i, enc, steps); end
      vec++; if (done_at != 1 || err !== 1'b1) begin errs++; $display("FAIL reject%0d_done got at=%0d err=%b want at=1 err=1", i, done_at, err); end
      vec++; if (fp !== 4'd9 || rdy !== 1'b1) begin errs++; $display("FAIL reject%0d_state got pos=%0d ready=%b want 9/1", i, fp, rdy); end
    end
  endtask

  // Position is 9 here; two inc-1 commands with Req held high end at 1.
  task automatic test_back_to_back();
    int  rises = 0, ready_busy = 0, n_done = -1;
    logic prev_en = 1'b0;
    bus.Req = 1'b1; bus.Mode = 2'b00; bus.Arg = 4'd1;
    tick();
    for (int n = 1; n <= 100; n++) begin
      if (bus.PulseEn === 1'b1 && !prev_en) rises++;
      prev_en = (bus.PulseEn === 1'b1);
      if (bus.Done === 1'b1) begin n_done = n; break; end
      if (bus.Ready === 1'b1) ready_busy++;
      tick();
    end
    vec++; if (n_done < 0 || rises != 1 || ready_busy != 0)
      begin errs++; $display("FAIL b2b_first got done=%0d rises=%0d readyhi=%0d want done>0 rises=1 readyhi=0", n_done, rises, ready_busy); end
    tick();
    vec++; if (bus.Ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_back got %b want 1", bus.Ready); end
    tick();
    vec++; if (bus.Ready !== 1'b0 || bus.Busy !== 1'b1)
      begin errs++; $display("FAIL b2b_second_accept got ready=%b busy=%b want 0/1", bus.Ready, bus.Busy); end
    bus.Req = 1'b0;
    n_done = -1;
    for (int n = 0; n < 100; n++) begin
      if (bus.Done === 1'b1) begin n_done = n; break; end
      tick();
    end
    vec++; if (n_done < 0 || bus.Position !== 4'd1)
      begin errs++; $display("FAIL b2b_second_done got done=%0d pos=%0d want done>=0 pos=1", n_done, bus.Position); end
    tick();
  endtask

  task automatic test_reset_mid();
    int enc = 0, bad = 0;
    do_reset();
    bus.Req = 1'b1; bus.Mode = 2'b00; bus.Arg = 4'd5;
    tick();
    bus.Req = 1'b0;
    for (int n = 0; n < 40 && enc < 15; n++) begin
      if (bus.PulseEn === 1'b1) enc++;
      tick();
    end
    vec++; if (bus.PulseEn !== 1'b1 || bus.Position !== 4'd1)
      begin errs++; $display("FAIL rstmid_setup got en=%b pos=%0d want 1/1", bus.PulseEn, bus.Position); end
    Rst = 1'b1;
    tick();
    vec++; if (bus.PulseEn !== 1'b0 || bus.Busy !== 1'b0 || bus.Ready !== 1'b1 || bus.Done !== 1'b0)
      begin errs++; $display("FAIL rstmid_ctrl got en=%b busy=%b ready=%b done=%b want 0/0/1/0",
                             bus.PulseEn, bus.Busy, bus.Ready, bus.Done); end
    vec++; if (bus.Position !== 4'd0 || dut.phase_q !== 4'd0)
      begin errs++; $display("FAIL rstmid_pos got pos=%0d phase=%0d want 0/0", bus.Position, dut.phase_q); end
    Rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (bus.Done === 1'b1 || bus.PulseEn === 1'b1) bad++;
      tick();
    end
    vec++; if (bad != 0) begin errs++; $display("FAIL rstmid_no_done got %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_dec();
    test_goto();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
